width_convert_gear: RTL and testbench

Parametrised stream width converter for the FIFO datapath. It replaces fixed up-conversion with a single block that up-converts, down-converts or passes through, chosen by the ratio of ISIZE to OSIZE. It adds lane ordering, partial-word flush on `wr_last` with a lane keep mask, and last propagation in both directions. It sits between a first-word-fall-through FIFO read port and the downstream consumer, on one clock domain.

---
 rtl/width_convert_gear.sv | 200 ++++++++++++++++++++
 tb/tb_width_convert_gear.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/width_convert_gear.sv
// Stream width converter placed behind a first-word-fall-through FIFO read port.
// Up-converts, down-converts or passes through, depending on ISIZE versus OSIZE.
// Narrow lanes are numbered in ORDER; rd_keep uses the same numbering.
module width_convert_gear #(
    parameter int    ISIZE     = 4,
    parameter int    OSIZE     = 8,
    parameter string ORDER     = "LSB",
    parameter int    PAD_VALUE = 0,
    localparam int   LANE      = (ISIZE < OSIZE) ? ISIZE : OSIZE,
    localparam int   WIDE      = (ISIZE < OSIZE) ? OSIZE : ISIZE,
    localparam int   N         = WIDE / LANE,
    localparam int   KW        = OSIZE / LANE
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [ISIZE-1:0] wr_data,
    input  logic             wr_vld,
    output logic             wr_ready,
    input  logic             wr_last,
    output logic [OSIZE-1:0] rd_data,
    output logic             rd_vld,
    input  logic             rd_ready,
    output logic             rd_last,
    output logic [KW-1:0]    rd_keep
);

    if ((WIDE % LANE) != 0) begin : g_bad_ratio
        $error("width_convert_gear: wider port must be a whole multiple of the narrower one");
    end

    if (OSIZE > ISIZE) begin : g_up
        localparam int              CW        = (N > 1) ? $clog2(N) : 1;
        localparam bit              MSB_FIRST = (ORDER == "MSB");
        localparam logic [LANE-1:0] PAD       = LANE'(PAD_VALUE);

        logic [CW-1:0]          cnt_q;
        logic [N-1:0][LANE-1:0] acc_q;
        logic [OSIZE-1:0]       data_q;
        logic [N-1:0]           keep_q;
        logic                   last_q;
        logic                   vld_q;
        logic                   ready_s;
        logic                   take_s;
        logic                   done_s;
        logic [OSIZE-1:0]       word_s;
        logic [N-1:0]           mask_s;
        logic [LANE-1:0]        lane_s;
        int                     pos_s;

        // Handshake: accept whenever the output slot is empty or drains this cycle
        always_comb begin
            ready_s = !rst && (!vld_q || rd_ready);
            take_s  = wr_vld && ready_s;
            done_s  = take_s && (wr_last || (cnt_q == CW'(N - 1)));
        end

        // Completed word: earlier lanes, the incoming lane, pad in the rest
        always_comb begin
            word_s = '0;
            mask_s = '0;
            lane_s = '0;
            pos_s  = 0;
            for (int j = 0; j < N; j++) begin
                if (j < int'(cnt_q)) begin
                    lane_s    = acc_q[j];
                    mask_s[j] = 1'b1;
                end else if (j == int'(cnt_q)) begin
                    lane_s    = wr_data;
                    mask_s[j] = 1'b1;
                end else begin
                    lane_s    = PAD;
                end
                pos_s = MSB_FIRST ? (N - 1 - j) : j;
                word_s[pos_s*LANE +: LANE] = lane_s;
            end
        end

        // Lane accumulation and output register load on completion
        always_ff @(posedge clock) begin
            if (rst) begin
                cnt_q  <= '0;
                acc_q  <= '0;
                data_q <= '0;
                keep_q <= '0;
                last_q <= 1'b0;
                vld_q  <= 1'b0;
            end else if (done_s) begin
                data_q <= word_s;
                keep_q <= mask_s;
                last_q <= wr_last;
                vld_q  <= 1'b1;
                cnt_q  <= '0;
                acc_q  <= '0;
            end else begin
                if (vld_q && rd_ready) begin
                    vld_q <= 1'b0;
                end
                if (take_s) begin
                    acc_q[cnt_q] <= wr_data;
                    cnt_q        <= cnt_q + CW'(1);
                end
            end
        end

        assign wr_ready = ready_s;
        assign rd_data  = data_q;
        assign rd_keep  = keep_q;
        assign rd_last  = last_q;
        assign rd_vld   = vld_q;
    end else if (ISIZE > OSIZE) begin : g_down
        localparam int CW        = (N > 1) ? $clog2(N) : 1;
        localparam bit MSB_FIRST = (ORDER == "MSB");

        logic [ISIZE-1:0] hold_q;
        logic [CW-1:0]    idx_q;
        logic             held_last_q;
        logic             vld_q;
        logic             keep_q;
        logic             end_s;
        logic             ready_s;
        logic             take_s;
        int               sel_s;

        // Handshake: a new wide word may load on the edge its predecessor's last lane leaves
        always_comb begin
            end_s   = (idx_q == CW'(N - 1));
            ready_s = !rst && (!vld_q || (rd_ready && end_s));
            take_s  = wr_vld && ready_s;
            sel_s   = MSB_FIRST ? (N - 1 - int'(idx_q)) : int'(idx_q);
        end

        // Hold register and lane index
        always_ff @(posedge clock) begin
            if (rst) begin
                hold_q      <= '0;
                idx_q       <= '0;
                held_last_q <= 1'b0;
                vld_q       <= 1'b0;
                keep_q      <= 1'b0;
            end else if (take_s) begin
                hold_q      <= wr_data;
                idx_q       <= '0;
                held_last_q <= wr_last;
                vld_q       <= 1'b1;
                keep_q      <= 1'b1;
            end else if (vld_q && rd_ready) begin
                if (end_s) begin
                    vld_q <= 1'b0;
                end else begin
                    idx_q <= idx_q + CW'(1);
                end
            end else begin
                vld_q <= vld_q;
            end
        end

        assign wr_ready = ready_s;
        assign rd_data  = hold_q[sel_s*LANE +: LANE];
        assign rd_keep  = keep_q;
        assign rd_last  = held_last_q && end_s;
        assign rd_vld   = vld_q;
    end else begin : g_pass
        logic [OSIZE-1:0] data_q;
        logic             last_q;
        logic             vld_q;
        logic             keep_q;
        logic             ready_s;

        // Handshake: single register stage with full throughput
        always_comb begin
            ready_s = !rst && (!vld_q || rd_ready);
        end

        // Single output register
        always_ff @(posedge clock) begin
            if (rst) begin
                data_q <= '0;
                last_q <= 1'b0;
                vld_q  <= 1'b0;
                keep_q <= 1'b0;
            end else if (wr_vld && ready_s) begin
                data_q <= wr_data;
                last_q <= wr_last;
                vld_q  <= 1'b1;
                keep_q <= 1'b1;
            end else if (rd_ready) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_q;
            end
        end

        assign wr_ready = ready_s;
        assign rd_data  = data_q;
        assign rd_keep  = keep_q;
        assign rd_last  = last_q;
        assign rd_vld   = vld_q;
    end

endmodule

// File: tb/tb_width_convert_gear.sv
`timescale 1ns/1ps
// Bench for width_convert_gear: up (LSB/MSB), down (LSB/MSB) and pass instances,
// directed vector tables plus random traffic against a transaction-level model.
module tb_width_convert_gear;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam logic [3:0] PAD = 4'h0;

    // Up group inputs (shared by LSB and MSB up instances)
    logic [3:0] u_wd;
    logic       u_wv, u_wl, u_rr;
    logic       ul_wr_ready, ul_rd_vld, ul_rd_last;
    logic [7:0] ul_rd_data;
    logic [1:0] ul_rd_keep;
    logic       um_wr_ready, um_rd_vld, um_rd_last;
    logic [7:0] um_rd_data;
    logic [1:0] um_rd_keep;

    // Down group inputs (shared by LSB/MSB down instances and the pass instance)
    logic [7:0] d_wd;
    logic       d_wv, d_wl, d_rr;
    logic       dl_wr_ready, dl_rd_vld, dl_rd_last;
    logic [3:0] dl_rd_data;
    logic [0:0] dl_rd_keep;
    logic       dm_wr_ready, dm_rd_vld, dm_rd_last;
    logic [3:0] dm_rd_data;
    logic [0:0] dm_rd_keep;
    logic       p_wr_ready, p_rd_vld, p_rd_last;
    logic [7:0] p_rd_data;
    logic [0:0] p_rd_keep;

    width_convert_gear #(.ISIZE(4), .OSIZE(8), .ORDER("LSB"), .PAD_VALUE(0)) u_up_lsb (
        .clock(clk), .rst(rst), .wr_data(u_wd), .wr_vld(u_wv), .wr_ready(ul_wr_ready),
        .wr_last(u_wl), .rd_data(ul_rd_data), .rd_vld(ul_rd_vld), .rd_ready(u_rr),
        .rd_last(ul_rd_last), .rd_keep(ul_rd_keep));

    width_convert_gear #(.ISIZE(4), .OSIZE(8), .ORDER("MSB"), .PAD_VALUE(0)) u_up_msb (
        .clock(clk), .rst(rst), .wr_data(u_wd), .wr_vld(u_wv), .wr_ready(um_wr_ready),
        .wr_last(u_wl), .rd_data(um_rd_data), .rd_vld(um_rd_vld), .rd_ready(u_rr),
        .rd_last(um_rd_last), .rd_keep(um_rd_keep));

    width_convert_gear #(.ISIZE(8), .OSIZE(4), .ORDER("LSB"), .PAD_VALUE(0)) u_dn_lsb (
        .clock(clk), .rst(rst), .wr_data(d_wd), .wr_vld(d_wv), .wr_ready(dl_wr_ready),
        .wr_last(d_wl), .rd_data(dl_rd_data), .rd_vld(dl_rd_vld), .rd_ready(d_rr),
        .rd_last(dl_rd_last), .rd_keep(dl_rd_keep));

    width_convert_gear #(.ISIZE(8), .OSIZE(4), .ORDER("MSB"), .PAD_VALUE(0)) u_dn_msb (
        .clock(clk), .rst(rst), .wr_data(d_wd), .wr_vld(d_wv), .wr_ready(dm_wr_ready),
        .wr_last(d_wl), .rd_data(dm_rd_data), .rd_vld(dm_rd_vld), .rd_ready(d_rr),
        .rd_last(dm_rd_last), .rd_keep(dm_rd_keep));

    width_convert_gear #(.ISIZE(8), .OSIZE(8), .ORDER("LSB"), .PAD_VALUE(0)) u_pass (
        .clock(clk), .rst(rst), .wr_data(d_wd), .wr_vld(d_wv), .wr_ready(p_wr_ready),
        .wr_last(d_wl), .rd_data(p_rd_data), .rd_vld(p_rd_vld), .rd_ready(d_rr),
        .rd_last(p_rd_last), .rd_keep(p_rd_keep));

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [3:0] up_acc[$];
    logic       uo_vld, uo_last;
    logic [7:0] uo_dl, uo_dm;
    logic [1:0] uo_keep;

    typedef struct packed {
        logic [3:0] l;
        logic [3:0] m;
        logic       last;
    } dlane_t;
    dlane_t dn_q[$];
    logic   dn_keep;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } pbeat_t;
    pbeat_t ps_q[$];
    logic   ps_keep;

    logic rst_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_models();
        logic up_rdy, dn_rdy, ps_rdy;
        up_rdy = !rst && (!uo_vld || u_rr);
        dn_rdy = !rst && (dn_q.size() == 0 || (dn_q.size() == 1 && d_rr));
        ps_rdy = !rst && (ps_q.size() == 0 || d_rr);

        chk("ul_wr_ready", ul_wr_ready, up_rdy);
        chk("um_wr_ready", um_wr_ready, up_rdy);
        chk("ul_rd_vld", ul_rd_vld, uo_vld);
        chk("um_rd_vld", um_rd_vld, uo_vld);
        if (uo_vld || rst_prev) begin
            chk("ul_rd_data", ul_rd_data, uo_dl);
            chk("um_rd_data", um_rd_data, uo_dm);
            chk("ul_rd_keep", ul_rd_keep, uo_keep);
            chk("um_rd_keep", um_rd_keep, uo_keep);
            chk("ul_rd_last", ul_rd_last, uo_last);
            chk("um_rd_last", um_rd_last, uo_last);
        end

        chk("dl_wr_ready", dl_wr_ready, dn_rdy);
        chk("dm_wr_ready", dm_wr_ready, dn_rdy);
        chk("dl_rd_vld", dl_rd_vld, dn_q.size() > 0);
        chk("dm_rd_vld", dm_rd_vld, dn_q.size() > 0);
        chk("dl_rd_keep", dl_rd_keep, dn_keep);
        chk("dm_rd_keep", dm_rd_keep, dn_keep);
        if (dn_q.size() > 0) begin
            chk("dl_rd_data", dl_rd_data, dn_q[0].l);
            chk("dm_rd_data", dm_rd_data, dn_q[0].m);
            chk("dl_rd_last", dl_rd_last, dn_q[0].last);
            chk("dm_rd_last", dm_rd_last, dn_q[0].last);
        end else if (rst_prev) begin
            chk("dl_rst_data", dl_rd_data, 0);
            chk("dm_rst_data", dm_rd_data, 0);
            chk("dl_rst_last", dl_rd_last, 0);
        end

        chk("p_wr_ready", p_wr_ready, ps_rdy);
        chk("p_rd_vld", p_rd_vld, ps_q.size() > 0);
        chk("p_rd_keep", p_rd_keep, ps_keep);
        if (ps_q.size() > 0) begin
            chk("p_rd_data", p_rd_data, ps_q[0].d);
            chk("p_rd_last", p_rd_last, ps_q[0].last);
        end else if (rst_prev) begin
            chk("p_rst_data", p_rd_data, 0);
            chk("p_rst_last", p_rd_last, 0);
        end
    endtask

    task automatic advance_models();
        logic       up_rdy, dn_rdy, ps_rdy;
        logic [7:0] lane;
        dlane_t     dl;
        pbeat_t     pb;
        up_rdy = !rst && (!uo_vld || u_rr);
        dn_rdy = !rst && (dn_q.size() == 0 || (dn_q.size() == 1 && d_rr));
        ps_rdy = !rst && (ps_q.size() == 0 || d_rr);
        if (rst) begin
            up_acc.delete();
            uo_vld = 1'b0; uo_last = 1'b0; uo_dl = 8'h00; uo_dm = 8'h00; uo_keep = 2'b00;
            dn_q.delete();
            dn_keep = 1'b0;
            ps_q.delete();
            ps_keep = 1'b0;
        end else begin
            if (uo_vld && u_rr) uo_vld = 1'b0;
            if (u_wv && up_rdy) begin
                up_acc.push_back(u_wd);
                if (up_acc.size() == 2 || u_wl) begin
                    uo_dl = 8'h00; uo_dm = 8'h00; uo_keep = 2'b00;
                    for (int k = 0; k < 2; k++) begin
                        lane = (k < up_acc.size()) ? {4'h0, up_acc[k]} : {4'h0, PAD};
                        uo_dl = uo_dl | (lane << (4 * k));
                        uo_dm = uo_dm | (lane << (4 * (1 - k)));
                        uo_keep[k] = (k < up_acc.size());
                    end
                    uo_last = u_wl;
                    uo_vld  = 1'b1;
                    up_acc.delete();
                end
            end

            if (dn_q.size() > 0 && d_rr) void'(dn_q.pop_front());
            if (d_wv && dn_rdy) begin
                for (int i = 0; i < 2; i++) begin
                    dl.l    = d_wd[4*i +: 4];
                    dl.m    = d_wd[4*(1-i) +: 4];
                    dl.last = d_wl && (i == 1);
                    dn_q.push_back(dl);
                end
                dn_keep = 1'b1;
            end

            if (ps_q.size() > 0 && d_rr) void'(ps_q.pop_front());
            if (d_wv && ps_rdy) begin
                pb.d    = d_wd;
                pb.last = d_wl;
                ps_q.push_back(pb);
                ps_keep = 1'b1;
            end
        end
        rst_prev = rst;
    endtask

    task automatic finish_cycle();
        check_models();
        advance_models();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    // ---------------- directed vector tables ----------------
    typedef struct packed {
        logic [7:0] wd;
        logic       wv, wl, rr;
        logic       e_rdy, e_vld;
        logic [7:0] e_data;
        logic [1:0] e_keep;
        logic       e_last;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] wd, input logic wv, input logic wl,
                                input logic rr, input logic e_rdy, input logic e_vld,
                                input logic [7:0] e_data, input logic [1:0] e_keep,
                                input logic e_last);
        vec_t v;
        v.wd = wd; v.wv = wv; v.wl = wl; v.rr = rr;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_keep = e_keep; v.e_last = e_last;
        return v;
    endfunction

    vec_t uv[12];
    vec_t dv[10];

    logic [7:0] got[$];
    logic [7:0] exp_w;
    int         sent;

    initial begin
        uo_vld = 1'b0; uo_last = 1'b0; uo_dl = 8'h00; uo_dm = 8'h00; uo_keep = 2'b00;
        dn_keep = 1'b0; ps_keep = 1'b0; rst_prev = 1'b1;
        u_wd = 4'h0; u_wv = 1'b0; u_wl = 1'b0; u_rr = 1'b1;
        d_wd = 8'h00; d_wv = 1'b0; d_wl = 1'b0; d_rr = 1'b1;

        //            wd     wv    wl    rr    rdy   vld   data   keep   last
        uv[0]  = mk(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        uv[1]  = mk(8'h0E, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        uv[2]  = mk(8'h0A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hEF, 2'b11, 1'b0);
        uv[3]  = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0A, 2'b01, 1'b1);
        uv[4]  = mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        uv[5]  = mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        uv[6]  = mk(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 2'b11, 1'b0);
        uv[7]  = mk(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h21, 2'b11, 1'b0);
        uv[8]  = mk(8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        uv[9]  = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43, 2'b11, 1'b0);
        uv[10] = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h43, 2'b11, 1'b0);
        uv[11] = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);

        dv[0]  = mk(8'hEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0);
        dv[1]  = mk(8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 2'b01, 1'b0);
        dv[2]  = mk(8'h12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0E, 2'b01, 1'b1);
        dv[3]  = mk(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 2'b01, 1'b0);
        dv[4]  = mk(8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 2'b01, 1'b0);
        dv[5]  = mk(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 2'b01, 1'b0);
        dv[6]  = mk(8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 2'b01, 1'b0);
        dv[7]  = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 2'b01, 1'b0);
        dv[8]  = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 2'b01, 1'b0);
        dv[9]  = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0);

        // Reset state
        tick();
        @(negedge clk);
        chk("reset_wr_ready", ul_wr_ready, 0);
        chk("reset_rd_vld", ul_rd_vld, 0);
        chk("reset_rd_keep", ul_rd_keep, 0);
        chk("reset_rd_data", ul_rd_data, 0);
        chk("reset_dn_keep", dl_rd_keep, 0);
        finish_cycle();
        rst = 1'b0;
        tick();

        // Up-mode vector table
        for (int i = 0; i < 12; i++) begin
            u_wd = uv[i].wd[3:0]; u_wv = uv[i].wv; u_wl = uv[i].wl; u_rr = uv[i].rr;
            @(negedge clk);
            chk("upvec_wr_ready", ul_wr_ready, uv[i].e_rdy);
            chk("upvec_rd_vld", ul_rd_vld, uv[i].e_vld);
            if (uv[i].e_vld) begin
                chk("upvec_rd_data", ul_rd_data, uv[i].e_data);
                chk("upvec_rd_keep", ul_rd_keep, uv[i].e_keep);
                chk("upvec_rd_last", ul_rd_last, uv[i].e_last);
            end
            finish_cycle();
        end
        u_wv = 1'b0; u_rr = 1'b1;

        // Down-mode vector table
        for (int i = 0; i < 10; i++) begin
            d_wd = dv[i].wd; d_wv = dv[i].wv; d_wl = dv[i].wl; d_rr = dv[i].rr;
            @(negedge clk);
            chk("dnvec_wr_ready", dl_wr_ready, dv[i].e_rdy);
            chk("dnvec_rd_vld", dl_rd_vld, dv[i].e_vld);
            if (dv[i].e_vld) begin
                chk("dnvec_rd_data", dl_rd_data, dv[i].e_data);
                chk("dnvec_rd_keep", dl_rd_keep, dv[i].e_keep);
                chk("dnvec_rd_last", dl_rd_last, dv[i].e_last);
            end
            finish_cycle();
        end
        d_wv = 1'b0; d_rr = 1'b1;
        tick();

        // Reset in the middle of an up-mode packet discards the partial lane
        u_wd = 4'h5; u_wv = 1'b1; u_wl = 1'b0; u_rr = 1'b1;
        tick();
        rst = 1'b1; u_wd = 4'h6;
        @(negedge clk);
        chk("midrst_wr_ready", ul_wr_ready, 0);
        finish_cycle();
        rst = 1'b0; u_wv = 1'b0;
        @(negedge clk);
        chk("postrst_rd_vld", ul_rd_vld, 0);
        chk("postrst_rd_data", ul_rd_data, 0);
        chk("postrst_rd_keep", ul_rd_keep, 0);
        chk("postrst_wr_ready", ul_wr_ready, 1);
        finish_cycle();
        u_wd = 4'h3; u_wv = 1'b1;
        tick();
        u_wd = 4'h4;
        tick();
        u_wv = 1'b0;
        @(negedge clk);
        chk("fresh_rd_vld", ul_rd_vld, 1);
        chk("fresh_rd_data", ul_rd_data, 8'h43);
        chk("fresh_rd_keep", ul_rd_keep, 2'b11);
        chk("fresh_rd_last", ul_rd_last, 0);
        finish_cycle();
        tick();

        // Output stalled for 10 cycles while 100 beats are offered
        sent = 0;
        got.delete();
        for (int cyc = 0; cyc < 400 && got.size() < 50; cyc++) begin
            u_rr = (cyc >= 10);
            u_wv = (sent < 100);
            u_wd = 4'(15 - (sent % 16));
            u_wl = 1'b0;
            @(negedge clk);
            if (cyc == 5) chk("stall_wr_ready", ul_wr_ready, 0);
            if (ul_rd_vld && u_rr) got.push_back(ul_rd_data);
            if (u_wv && ul_wr_ready) sent++;
            finish_cycle();
        end
        u_wv = 1'b0; u_rr = 1'b1;
        chk("stall_out_count", got.size(), 50);
        for (int j = 0; j < got.size(); j++) begin
            exp_w = {4'(15 - ((2 * j + 1) % 16)), 4'(15 - ((2 * j) % 16))};
            chk("stall_out_word", got[j], exp_w);
        end
        tick();

        // Random traffic on all instances
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst  = ($urandom_range(0, 249) == 0);
            u_wd = 4'($urandom_range(0, 15));
            u_wv = ($urandom_range(0, 3) != 0);
            u_wl = ($urandom_range(0, 4) == 0);
            u_rr = (cyc % 500 < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            d_wd = 8'($urandom_range(0, 255));
            d_wv = (cyc % 500 < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            d_wl = ($urandom_range(0, 2) == 0);
            d_rr = (cyc % 500 < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; u_wv = 1'b0; d_wv = 1'b0; u_rr = 1'b1; d_rr = 1'b1;
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
